// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Gathers branch resolutions from the execute ports and picks the oldest
// mispredict. It issues validate strobes and a recall pulse to the
// checkpointer, redirects fetch, and holds the front end through a short
// drain window.
// Optional feature macro: BRU_PERF_EN enables saturating perf counters.
// Without the macro, perf outputs are tied to zero.

`ifndef NUM_CHECKPOINTS
`define NUM_CHECKPOINTS 8
`endif
`ifndef NUM_BRANCHES_RESOLVED
`define NUM_BRANCHES_RESOLVED 2
`endif

module branch_resolve_unit #(
   parameter int NUM_CHECKPOINTS = `NUM_CHECKPOINTS,
   parameter int NUM_PORTS       = `NUM_BRANCHES_RESOLVED,
   parameter int RECOVER_CYCLES  = 2,
   localparam int CW = (NUM_CHECKPOINTS > 1) ? $clog2(NUM_CHECKPOINTS) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_PORTS-1:0]               br_valid,
   input  logic [NUM_PORTS-1:0][CW-1:0]       br_cp_id,
   input  logic [NUM_PORTS-1:0]               br_mispredict,
   input  logic [NUM_PORTS-1:0][63:0]         br_target,
   input  logic [CW-1:0]                      cp_back,
   output logic [NUM_PORTS-1:0]               validate,
   output logic [NUM_PORTS-1:0][CW-1:0]       validated_id,
   output logic                               recall_checkpoint,
   output logic [CW-1:0]                      recall_id,
   output logic                               redirect_valid,
   output logic [63:0]                        redirect_pc,
   output logic                               recover_busy,
   output logic [31:0]                        perf_resolved,
   output logic [31:0]                        perf_mispredict
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECALL = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   // Age relative to the oldest live checkpoint; wraps in CW bits.
   function automatic logic [CW-1:0] age_of(input logic [CW-1:0] id,
                                            input logic [CW-1:0] base);
      return id - base;
   endfunction

   state_t                          state_r;
   logic [3:0]                      cnt_r;
   logic [CW-1:0]                   recall_id_r;
   logic [63:0]                     redirect_pc_r;
   logic                            recall_pulse_r;
   logic                            redirect_pulse_r;
   logic [NUM_PORTS-1:0]            validate_r;
   logic [NUM_PORTS-1:0][CW-1:0]    validated_id_r;

   logic [NUM_PORTS-1:0][CW-1:0]    port_age_s;
   logic                            cand_valid_s;
   logic [PW-1:0]                   cand_port_s;
   logic [CW-1:0]                   cand_age_s;
   logic [CW-1:0]                   cand_id_s;
   logic [63:0]                     cand_pc_s;
   logic [CW-1:0]                   recall_age_s;
   logic                            active_s;
   logic                            accept_s;
   logic [NUM_PORTS-1:0]            validate_nxt_s;
   logic [NUM_PORTS-1:0][CW-1:0]    validated_id_nxt_s;

   // Oldest mispredicting port: strict compare keeps the lowest index on ties.
   always_comb begin
      port_age_s   = '0;
      cand_valid_s = 1'b0;
      cand_port_s  = '0;
      cand_age_s   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         logic take;
         port_age_s[i] = age_of(br_cp_id[i], cp_back);
         take = br_valid[i] & br_mispredict[i] &
                (~cand_valid_s | (port_age_s[i] < cand_age_s));
         cand_valid_s = take ? 1'b1 : cand_valid_s;
         cand_port_s  = take ? PW'(i) : cand_port_s;
         cand_age_s   = take ? port_age_s[i] : cand_age_s;
      end
   end

   assign cand_id_s    = br_cp_id[cand_port_s];
   assign cand_pc_s    = br_target[cand_port_s];
   assign recall_age_s = age_of(recall_id_r, cp_back);
   assign active_s     = (state_r != ST_IDLE);
   assign accept_s     = cand_valid_s & (~active_s | (cand_age_s < recall_age_s));

   // Correct branches survive only if strictly older than any recall issued now or in flight.
   always_comb begin
      validate_nxt_s     = '0;
      validated_id_nxt_s = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         logic keep;
         keep = br_valid[i] & ~br_mispredict[i] &
                ~(accept_s & (cand_age_s <= port_age_s[i])) &
                ~(active_s & (recall_age_s <= port_age_s[i]));
         validate_nxt_s[i]     = keep;
         validated_id_nxt_s[i] = keep ? br_cp_id[i] : {CW{1'b0}};
      end
   end

   // Recovery sequencer: latch the recall, pulse once, then drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r          <= ST_IDLE;
         cnt_r            <= 4'd0;
         recall_id_r      <= '0;
         redirect_pc_r    <= 64'd0;
         recall_pulse_r   <= 1'b0;
         redirect_pulse_r <= 1'b0;
      end else if (accept_s) begin
         state_r          <= ST_RECALL;
         cnt_r            <= 4'd0;
         recall_id_r      <= cand_id_s;
         redirect_pc_r    <= cand_pc_s;
         recall_pulse_r   <= 1'b1;
         redirect_pulse_r <= 1'b1;
      end else begin
         recall_pulse_r   <= 1'b0;
         redirect_pulse_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               state_r <= ST_IDLE;
               cnt_r   <= 4'd0;
            end
            ST_RECALL: begin
               state_r <= ST_DRAIN;
               cnt_r   <= RECOVER_LOAD;
            end
            ST_DRAIN: begin
               if (cnt_r <= 4'd1) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= 4'd0;
               end else begin
                  state_r <= ST_DRAIN;
                  cnt_r   <= cnt_r - 4'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 4'd0;
            end
         endcase
      end
   end

   // Registered validation strobes, one cycle after the resolution.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         validate_r     <= '0;
         validated_id_r <= '0;
      end else begin
         validate_r     <= validate_nxt_s;
         validated_id_r <= validated_id_nxt_s;
      end
   end

   assign validate          = validate_r;
   assign validated_id      = validated_id_r;
   assign recall_checkpoint = recall_pulse_r;
   assign recall_id         = recall_id_r;
   assign redirect_valid    = redirect_pulse_r;
   assign redirect_pc       = redirect_pc_r;
   // Busy also covers the cycle a mispredict is being latched; forced low in reset.
   assign recover_busy      = reset & (active_s | accept_s);

`ifdef BRU_PERF_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   logic [31:0] perf_res_r;
   logic [31:0] perf_mis_r;
   logic [31:0] res_inc_s;
   logic [31:0] mis_inc_s;

   // Count valid and mispredicting ports this cycle.
   always_comb begin
      res_inc_s = 32'd0;
      mis_inc_s = 32'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         res_inc_s = res_inc_s + 32'(br_valid[i]);
         mis_inc_s = mis_inc_s + 32'(br_valid[i] & br_mispredict[i]);
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_res_r <= 32'd0;
         perf_mis_r <= 32'd0;
      end else begin
         perf_res_r <= sat_add(perf_res_r, res_inc_s);
         perf_mis_r <= sat_add(perf_mis_r, mis_inc_s);
      end
   end

   assign perf_resolved   = perf_res_r;
   assign perf_mispredict = perf_mis_r;
`else
   assign perf_resolved   = 32'd0;
   assign perf_mispredict = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit (8 checkpoints, 2 ports, 2 drain cycles).
module tb_branch_resolve_unit;

   localparam int NC = 8;
   localparam int NP = 2;
   localparam int CW = 3;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NP-1:0]            br_valid;
   logic [NP-1:0][CW-1:0]    br_cp_id;
   logic [NP-1:0]            br_mispredict;
   logic [NP-1:0][63:0]      br_target;
   logic [CW-1:0]            cp_back;
   logic [NP-1:0]            validate;
   logic [NP-1:0][CW-1:0]    validated_id;
   logic                     recall_checkpoint;
   logic [CW-1:0]            recall_id;
   logic                     redirect_valid;
   logic [63:0]              redirect_pc;
   logic                     recover_busy;
   logic [31:0]              perf_resolved;
   logic [31:0]              perf_mispredict;

   int err_cnt = 0;
   int chk_cnt = 0;

   branch_resolve_unit #(
      .NUM_CHECKPOINTS(NC),
      .NUM_PORTS(NP),
      .RECOVER_CYCLES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .br_valid(br_valid),
      .br_cp_id(br_cp_id),
      .br_mispredict(br_mispredict),
      .br_target(br_target),
      .cp_back(cp_back),
      .validate(validate),
      .validated_id(validated_id),
      .recall_checkpoint(recall_checkpoint),
      .recall_id(recall_id),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .recover_busy(recover_busy),
      .perf_resolved(perf_resolved),
      .perf_mispredict(perf_mispredict)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      br_valid      = '0;
      br_mispredict = '0;
      br_cp_id      = '0;
      br_target     = '0;
   endtask

   task automatic drive(input int p, input logic [CW-1:0] id, input logic misp, input logic [63:0] tgt);
      br_valid[p]      = 1'b1;
      br_cp_id[p]      = id;
      br_mispredict[p] = misp;
      br_target[p]     = tgt;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      cp_back = '0;
      idle_inputs();
      #12;
      check_eq("rst_validate", 64'(validate), 64'd0);
      check_eq("rst_recall", 64'(recall_checkpoint), 64'd0);
      check_eq("rst_recall_id", 64'(recall_id), 64'd0);
      check_eq("rst_redirect_pc", redirect_pc, 64'd0);
      check_eq("rst_busy", 64'(recover_busy), 64'd0);
      check_eq("rst_perf_res", 64'(perf_resolved), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Plain validation, one cycle latency.
      drive(0, 3'd3, 1'b0, 64'h0);
      tick();
      check_eq("val_strobe", 64'(validate), 64'd1);
      check_eq("val_id0", 64'(validated_id[0]), 64'd3);
      check_eq("val_no_recall", 64'(recall_checkpoint), 64'd0);
      idle_inputs();

      // Oldest of two mispredicts with wrapped ages (cp_back=6).
      cp_back = 3'd6;
      drive(0, 3'd1, 1'b1, 64'h400);
      drive(1, 3'd7, 1'b1, 64'h800);
      #1;
      check_eq("busy_latch_cycle", 64'(recover_busy), 64'd1);
      tick();
      check_eq("age_recall", 64'(recall_checkpoint), 64'd1);
      check_eq("age_redirect_v", 64'(redirect_valid), 64'd1);
      check_eq("age_recall_id", 64'(recall_id), 64'd7);
      check_eq("age_redirect_pc", redirect_pc, 64'h800);
      check_eq("age_no_validate", 64'(validate), 64'd0);
      idle_inputs();
      tick();
      check_eq("age_pulse_end", 64'(recall_checkpoint), 64'd0);
      check_eq("age_busy_d1", 64'(recover_busy), 64'd1);
      tick();
      check_eq("age_busy_d2", 64'(recover_busy), 64'd1);
      tick();
      check_eq("age_busy_off", 64'(recover_busy), 64'd0);

      // Validate older + recall in the same cycle; younger follower dropped.
      cp_back = 3'd0;
      drive(0, 3'd2, 1'b0, 64'h0);
      drive(1, 3'd4, 1'b1, 64'h1000);
      tick();
      check_eq("same_validate", 64'(validate), 64'd1);
      check_eq("same_val_id0", 64'(validated_id[0]), 64'd2);
      check_eq("same_recall", 64'(recall_checkpoint), 64'd1);
      check_eq("same_recall_id", 64'(recall_id), 64'd4);
      check_eq("same_redirect_pc", redirect_pc, 64'h1000);
      idle_inputs();
      drive(0, 3'd5, 1'b0, 64'h0);
      drive(1, 3'd3, 1'b0, 64'h0);
      tick();
      check_eq("drop_younger", 64'(validate), 64'd2);
      check_eq("keep_older_id1", 64'(validated_id[1]), 64'd3);
      idle_inputs();
      tick();
      tick();
      check_eq("same_busy_off", 64'(recover_busy), 64'd0);

      // Age tie: lowest port wins.
      drive(0, 3'd3, 1'b1, 64'hAAA);
      drive(1, 3'd3, 1'b1, 64'hBBB);
      tick();
      check_eq("tie_recall_id", 64'(recall_id), 64'd3);
      check_eq("tie_redirect_pc", redirect_pc, 64'hAAA);
      idle_inputs();
      tick();
      tick();
      tick();
      check_eq("tie_busy_off", 64'(recover_busy), 64'd0);

      // Preemption by an older mispredict during DRAIN; younger one ignored.
      drive(0, 3'd5, 1'b1, 64'h500);
      tick();
      check_eq("pre_first_id", 64'(recall_id), 64'd5);
      idle_inputs();
      tick();
      check_eq("pre_drain_pulse", 64'(recall_checkpoint), 64'd0);
      drive(1, 3'd2, 1'b1, 64'h200);
      tick();
      check_eq("pre_recall", 64'(recall_checkpoint), 64'd1);
      check_eq("pre_recall_id", 64'(recall_id), 64'd2);
      check_eq("pre_redirect_pc", redirect_pc, 64'h200);
      idle_inputs();
      tick();
      check_eq("pre_restart_busy", 64'(recover_busy), 64'd1);
      drive(0, 3'd6, 1'b1, 64'h600);
      tick();
      check_eq("ign_recall", 64'(recall_checkpoint), 64'd0);
      check_eq("ign_recall_id", 64'(recall_id), 64'd2);
      check_eq("ign_redirect_pc", redirect_pc, 64'h200);
      check_eq("ign_busy", 64'(recover_busy), 64'd1);
      idle_inputs();
      tick();
      check_eq("ign_busy_off", 64'(recover_busy), 64'd0);

      // Asynchronous reset in the middle of DRAIN.
      drive(0, 3'd3, 1'b1, 64'h300);
      tick();
      idle_inputs();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check_eq("mid_rst_recall_id", 64'(recall_id), 64'd0);
      check_eq("mid_rst_pc", redirect_pc, 64'd0);
      check_eq("mid_rst_busy", 64'(recover_busy), 64'd0);
      check_eq("mid_rst_recall", 64'(recall_checkpoint), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_eq("post_rst_recall", 64'(recall_checkpoint), 64'd0);
      check_eq("post_rst_busy", 64'(recover_busy), 64'd0);
      tick();
      check_eq("post_rst_recall2", 64'(recall_checkpoint), 64'd0);

      // Perf counters: 10 cycles of two valid ports, 3 mispredicts total.
      for (int c = 0; c < 10; c++) begin
         br_valid      = 2'b11;
         br_cp_id[0]   = 3'(c);
         br_cp_id[1]   = 3'(c + 1);
         br_target     = '0;
         br_mispredict = (c == 0) ? 2'b01 : (c == 4) ? 2'b10 : (c == 8) ? 2'b01 : 2'b00;
         tick();
      end
      idle_inputs();
`ifdef BRU_PERF_EN
      check_eq("perf_resolved", 64'(perf_resolved), 64'd20);
      check_eq("perf_mispredict", 64'(perf_mispredict), 64'd3);
`else
      check_eq("perf_resolved_off", 64'(perf_resolved), 64'd0);
      check_eq("perf_mispredict_off", 64'(perf_mispredict), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
